// File: rtl/mem_stage.sv
// Pipeline MEM stage: word-addressed data memory with a fixed number of wait
// states, misaligned-access detection, branch resolution and the MEM/WB register.
module mem_stage #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] ALU_VAL,
  input  logic [31:0] RT_READ,
  input  logic [31:0] BRANCH,
  input  logic        ZERO,
  input  logic [4:0]  REG_DESTINATION,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic        MEM_TO_REG,
  input  logic        REG_WRITE,
  input  logic        BRANCH_CTRL,
  output logic        STALL,
  output logic        PC_SRC,
  output logic [31:0] BRANCH_TARGET,
  output logic        ALIGN_ERR,
  output logic [31:0] READ_DATA_OUT,
  output logic [31:0] ALU_VAL_OUT,
  output logic [4:0]  REG_DESTINATION_OUT,
  output logic        MEM_TO_REG_OUT,
  output logic        REG_WRITE_OUT
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] LOAD_CNT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam bit         HAS_WAIT = (WAIT_CYCLES != 0);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] mem [2**DEPTH_LOG2];

  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  mem_req;
  logic                  misaligned;
  logic                  mem_op;
  logic [31:0]           mem_rdata;

  assign word_idx   = ALU_VAL[DEPTH_LOG2+1:2];
  assign mem_req    = MEM_READ | MEM_WRITE;
  assign misaligned = mem_req & (ALU_VAL[1:0] != 2'b00);
  assign mem_op     = mem_req & (ALU_VAL[1:0] == 2'b00);
  assign mem_rdata  = mem[word_idx];

  // Branch resolution does not depend on the memory FSM at all.
  assign PC_SRC        = BRANCH_CTRL & ZERO;
  assign BRANCH_TARGET = BRANCH;

  // Stall while waiting; the final wait-free cycle is the capture cycle.
  assign STALL = !RESET &&
                 (((state == IDLE) && mem_op && HAS_WAIT) ||
                  ((state == BUSY) && (cnt != 4'd0)));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state               <= IDLE;
      cnt                 <= 4'd0;
      ALIGN_ERR           <= 1'b0;
      READ_DATA_OUT       <= 32'h0;
      ALU_VAL_OUT         <= 32'h0;
      REG_DESTINATION_OUT <= 5'd0;
      MEM_TO_REG_OUT      <= 1'b0;
      REG_WRITE_OUT       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      ALIGN_ERR <= misaligned;

      case (state)
        IDLE: begin
          if (mem_op && HAS_WAIT) begin
            state <= BUSY;
            cnt   <= LOAD_CNT;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else             state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (STALL || misaligned) begin
        // Bubble: kill the write-back controls, keep the data fields.
        MEM_TO_REG_OUT <= 1'b0;
        REG_WRITE_OUT  <= 1'b0;
      end else begin
        READ_DATA_OUT       <= (mem_op && MEM_READ && !MEM_WRITE) ? mem_rdata : 32'h0;
        ALU_VAL_OUT         <= ALU_VAL;
        REG_DESTINATION_OUT <= REG_DESTINATION;
        MEM_TO_REG_OUT      <= MEM_TO_REG;
        REG_WRITE_OUT       <= REG_WRITE;
      end
    end
  end

  // NOTE: the data array is deliberately not reset; contents must survive
  // RESET, and a reset would also prevent mapping onto RAM macros.
  always_ff @(posedge CLK) begin
    if (!RESET && !STALL && mem_op && MEM_WRITE)
      mem[word_idx] <= RT_READ;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scenario-driven bench for mem_stage: expected MEM/WB contents are queued when
// an instruction is issued and compared when the stage captures it.
module tb_mem_stage;

  localparam int WAIT = 2;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  dest;
    logic        mtr;
    logic        rw;
  } wb_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] ALU_VAL, RT_READ, BRANCH;
  logic        ZERO;
  logic [4:0]  REG_DESTINATION;
  logic        MEM_READ, MEM_WRITE, MEM_TO_REG, REG_WRITE, BRANCH_CTRL;
  logic        STALL, PC_SRC, ALIGN_ERR;
  logic [31:0] BRANCH_TARGET, READ_DATA_OUT, ALU_VAL_OUT;
  logic [4:0]  REG_DESTINATION_OUT;
  logic        MEM_TO_REG_OUT, REG_WRITE_OUT;

  int          vectors = 0;
  int          miscompares = 0;
  wb_t         exp_q[$];
  logic [31:0] model [256];

  mem_stage #(.DEPTH_LOG2(8), .WAIT_CYCLES(WAIT)) dut (
    .CLK(CLK), .RESET(RESET), .ALU_VAL(ALU_VAL), .RT_READ(RT_READ),
    .BRANCH(BRANCH), .ZERO(ZERO), .REG_DESTINATION(REG_DESTINATION),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_TO_REG(MEM_TO_REG),
    .REG_WRITE(REG_WRITE), .BRANCH_CTRL(BRANCH_CTRL), .STALL(STALL),
    .PC_SRC(PC_SRC), .BRANCH_TARGET(BRANCH_TARGET), .ALIGN_ERR(ALIGN_ERR),
    .READ_DATA_OUT(READ_DATA_OUT), .ALU_VAL_OUT(ALU_VAL_OUT),
    .REG_DESTINATION_OUT(REG_DESTINATION_OUT), .MEM_TO_REG_OUT(MEM_TO_REG_OUT),
    .REG_WRITE_OUT(REG_WRITE_OUT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    MEM_READ = 0; MEM_WRITE = 0; MEM_TO_REG = 0; REG_WRITE = 0;
    BRANCH_CTRL = 0; ZERO = 0; BRANCH = 32'h0;
    ALU_VAL = 32'h0; RT_READ = 32'h0; REG_DESTINATION = 5'd0;
  endtask

  // Issue one instruction at a falling edge and follow it to its capture edge.
  task automatic do_op(input logic rd, input logic wr, input logic mtr, input logic rw,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] dest);
    wb_t  e, got;
    logic misal;
    int   idx, stalls, exp_stalls;
    bit   done;
    misal = (rd | wr) && (addr[1:0] != 2'b00);
    idx   = int'(addr[9:2]);
    e.alu   = addr;
    e.dest  = dest;
    e.mtr   = misal ? 1'b0 : mtr;
    e.rw    = misal ? 1'b0 : rw;
    e.rdata = (rd && !wr && !misal) ? model[idx] : 32'h0;
    if (wr && !misal) model[idx] = data;
    exp_q.push_back(e);
    exp_stalls = ((rd | wr) && !misal) ? WAIT : 0;

    MEM_READ = rd; MEM_WRITE = wr; MEM_TO_REG = mtr; REG_WRITE = rw;
    ALU_VAL = addr; RT_READ = data; REG_DESTINATION = dest;

    stalls = 0;
    done   = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      if (STALL) begin
        stalls++;
        @(posedge CLK); @(negedge CLK);
        vectors++;
        if (REG_WRITE_OUT !== 1'b0 || MEM_TO_REG_OUT !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_bubble addr=%h: rw=%b mtr=%b, required 0 0",
                   addr, REG_WRITE_OUT, MEM_TO_REG_OUT);
        end
      end else begin
        @(posedge CLK); @(negedge CLK);
        done = 1;
      end
    end

    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL capture_timeout addr=%h: no capture within 20 cycles", addr);
    end
    vectors++;
    if (stalls != exp_stalls) begin
      miscompares++;
      $display("FAIL stall_count addr=%h: got %0d, required %0d", addr, stalls, exp_stalls);
    end
    vectors++;
    if (ALIGN_ERR !== misal) begin
      miscompares++;
      $display("FAIL align_err addr=%h: got %b, required %b", addr, ALIGN_ERR, misal);
    end

    e   = exp_q.pop_front();
    got = '{READ_DATA_OUT, ALU_VAL_OUT, REG_DESTINATION_OUT, MEM_TO_REG_OUT, REG_WRITE_OUT};
    vectors++;
    if (misal) begin
      if (got.rw !== e.rw || got.mtr !== e.mtr) begin
        miscompares++;
        $display("FAIL bubble_ctrl addr=%h: rw=%b mtr=%b, required %b %b",
                 addr, got.rw, got.mtr, e.rw, e.mtr);
      end
    end else if (got !== e) begin
      miscompares++;
      $display("FAIL memwb addr=%h: rdata=%h alu=%h dest=%0d mtr=%b rw=%b, required %h %h %0d %b %b",
               addr, got.rdata, got.alu, got.dest, got.mtr, got.rw,
               e.rdata, e.alu, e.dest, e.mtr, e.rw);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    vectors++;
    if ({ALIGN_ERR, READ_DATA_OUT, ALU_VAL_OUT, REG_DESTINATION_OUT,
         MEM_TO_REG_OUT, REG_WRITE_OUT, STALL} !== '0) begin
      miscompares++;
      $display("FAIL %s: ae=%b rd=%h alu=%h dst=%0d mtr=%b rw=%b stall=%b, required all 0",
               tag, ALIGN_ERR, READ_DATA_OUT, ALU_VAL_OUT, REG_DESTINATION_OUT,
               MEM_TO_REG_OUT, REG_WRITE_OUT, STALL);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_outputs_zero("reset_state");
    RESET = 1'b0;
  endtask

  task automatic test_store_load();
    do_op(0, 1, 0, 0, 32'h10, 32'hDEADBEEF, 5'd0);
    do_op(1, 0, 1, 1, 32'h10, 32'h0, 5'd5);
  endtask

  task automatic test_misaligned();
    do_op(1, 0, 1, 1, 32'h13, 32'h0, 5'd7);
    do_op(0, 1, 0, 0, 32'h12, 32'h11111111, 5'd0);
    idle_inputs();
    @(posedge CLK); @(negedge CLK);
    vectors++;
    if (ALIGN_ERR !== 1'b0) begin
      miscompares++;
      $display("FAIL align_pulse_width: got %b, required 0", ALIGN_ERR);
    end
    do_op(1, 0, 1, 1, 32'h10, 32'h0, 5'd5);
  endtask

  task automatic test_alu_branch();
    BRANCH_CTRL = 1; ZERO = 1; BRANCH = 32'h40;
    #1;
    vectors++;
    if (PC_SRC !== 1'b1 || BRANCH_TARGET !== 32'h40) begin
      miscompares++;
      $display("FAIL branch_taken: pc_src=%b target=%h, required 1 00000040", PC_SRC, BRANCH_TARGET);
    end
    do_op(0, 0, 0, 1, 32'h1234, 32'h0, 5'd9);
    ZERO = 0;
    #1;
    vectors++;
    if (PC_SRC !== 1'b0) begin
      miscompares++;
      $display("FAIL branch_not_taken: pc_src=%b, required 0", PC_SRC);
    end
    // Branch outputs stay live while a memory op is stalling.
    ZERO = 1; BRANCH = 32'h80; MEM_WRITE = 1; ALU_VAL = 32'h30; RT_READ = 32'h3;
    model[12] = 32'h3;
    #1;
    vectors++;
    if (STALL !== 1'b1 || PC_SRC !== 1'b1 || BRANCH_TARGET !== 32'h80) begin
      miscompares++;
      $display("FAIL branch_during_stall: stall=%b pc_src=%b target=%h, required 1 1 00000080",
               STALL, PC_SRC, BRANCH_TARGET);
    end
    repeat (WAIT + 1) @(posedge CLK);
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic test_wrap();
    do_op(0, 1, 0, 0, 32'h0, 32'hAAAA0000, 5'd0);
    do_op(0, 1, 0, 0, 32'h400, 32'h55, 5'd0);
    do_op(1, 0, 1, 1, 32'h0, 32'h0, 5'd3);
  endtask

  task automatic test_read_write_both();
    do_op(1, 1, 1, 1, 32'h20, 32'h77, 5'd4);
    do_op(1, 0, 1, 1, 32'h20, 32'h0, 5'd4);
  endtask

  task automatic test_reset_busy();
    MEM_WRITE = 1; ALU_VAL = 32'h20; RT_READ = 32'h99;
    @(posedge CLK); @(negedge CLK);
    vectors++;
    if (STALL !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_before_reset: stall=%b, required 1", STALL);
    end
    #2 RESET = 1'b1;
    #1 check_outputs_zero("reset_in_busy");
    @(posedge CLK); @(negedge CLK);
    check_outputs_zero("reset_held");
    idle_inputs();
    RESET = 1'b0;
    do_op(1, 0, 1, 1, 32'h20, 32'h0, 5'd6);
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr;
    for (int i = 0; i < 4; i++)
      do_op(0, 1, 0, 0, 32'h100 + 32'(i * 4), $urandom, 5'd0);
    for (int i = 0; i < 12; i++) begin
      addr = 32'h100 + 32'($urandom_range(0, 3) * 4);
      case ($urandom_range(0, 3))
        0:       do_op(0, 1, 0, 0, addr, $urandom, 5'd0);
        1:       do_op(0, 0, 0, 1, $urandom, 32'h0, 5'($urandom));
        2:       do_op(1, 0, 1, 1, addr + 32'd1, 32'h0, 5'd2);
        default: do_op(1, 0, 1, 1, addr, 32'h0, 5'($urandom));
      endcase
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    RESET = 1'b1;
    @(negedge CLK);
    test_reset();
    test_store_load();
    test_misaligned();
    test_alu_branch();
    test_wrap();
    test_read_write_both();
    test_reset_busy();
    test_back_to_back();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, log2 of data-memory depth in 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2, memory wait states per load/store (legal 0..15).
REQ-003 CLK  input  1  clock; all state updates on rising edge.
REQ-004 RESET  input  1  reset, asynchronous, active-high.
REQ-005 ALU_VAL  input  32  byte address for load/store; result for ALU ops.
REQ-006 RT_READ  input  32  store data.
REQ-007 BRANCH  input  32  branch target address.
REQ-008 ZERO  input  1  ALU zero flag.
REQ-009 REG_DESTINATION  input  5  write-back register index.
REQ-010 MEM_READ, MEM_WRITE, MEM_TO_REG, REG_WRITE, BRANCH_CTRL  input  1 each  control bits for the instruction in this stage.
REQ-011 STALL  output  1  combinational; high means upstream holds all inputs stable.
REQ-012 PC_SRC  output  1  combinational; BRANCH_CTRL & ZERO.
REQ-013 BRANCH_TARGET  output  32  combinational copy of BRANCH.
REQ-014 ALIGN_ERR  output  1  registered one-cycle pulse for a misaligned access.
REQ-015 READ_DATA_OUT, ALU_VAL_OUT  output  32 each  MEM/WB register data fields.
REQ-016 REG_DESTINATION_OUT  output  5  MEM/WB register index.
REQ-017 MEM_TO_REG_OUT, REG_WRITE_OUT  output  1 each  MEM/WB register control fields.

Function
REQ-018 Internal array SHALL be 2**DEPTH_LOG2 x 32; word index = ALU_VAL[DEPTH_LOG2+1:2]; upper address bits ignored (wrap-around).
REQ-019 Memory op = (MEM_READ | MEM_WRITE) with ALU_VAL[1:0]==0; if ALU_VAL[1:0]!=0 with MEM_READ|MEM_WRITE: no access, no stall, ALIGN_ERR=1 next cycle, MEM/WB loads a bubble.
REQ-020 FSM states IDLE and BUSY plus a 4-bit wait counter CNT.
REQ-021 IDLE, memory op, WAIT_CYCLES>0: STALL=1, next state BUSY, CNT<=WAIT_CYCLES-1.
REQ-022 BUSY, CNT!=0: STALL=1, CNT<=CNT-1, stay BUSY.
REQ-023 BUSY, CNT==0: STALL=0, perform access and capture MEM/WB this edge, next state IDLE.
REQ-024 WAIT_CYCLES=0 or non-memory op in IDLE: STALL=0, access/capture same cycle, stay IDLE.
REQ-025 Memory op therefore occupies exactly WAIT_CYCLES+1 cycles; STALL high for the first WAIT_CYCLES.
REQ-026 Store SHALL write RT_READ to the array exactly once, on the capture edge only.
REQ-027 Load SHALL read the array combinationally at the indexed word; READ_DATA_OUT loads it on the capture edge.
REQ-028 MEM_READ and MEM_WRITE both high: write performed, READ_DATA_OUT loads 0.
REQ-029 Non-load capture: READ_DATA_OUT loads 0.
REQ-030 On capture: ALU_VAL_OUT, REG_DESTINATION_OUT, MEM_TO_REG_OUT, REG_WRITE_OUT load their inputs.
REQ-031 Each cycle with STALL=1: REG_WRITE_OUT<=0 and MEM_TO_REG_OUT<=0 (bubble); data fields hold.
REQ-032 PC_SRC and BRANCH_TARGET SHALL be independent of FSM state.

Reset
REQ-033 RESET high: FSM IDLE, CNT 0, all registered outputs 0, including ALIGN_ERR and every MEM/WB field.
REQ-034 RESET during BUSY: abandon access with no array write; array contents unaffected by RESET.
REQ-035 First rising CLK after RESET deasserts operates from IDLE.

Verification
REQ-036 WAIT_CYCLES=2, store ALU_VAL=0x10, RT_READ=0xDEADBEEF -> STALL high for 2 cycles; word 4 written on 3rd edge only.
REQ-037 Then load ALU_VAL=0x10, MEM_TO_REG=1, REG_WRITE=1, dest 5 -> after 3 edges READ_DATA_OUT=0xDEADBEEF, REG_DESTINATION_OUT=5, REG_WRITE_OUT=1; REG_WRITE_OUT=0 on the 2 stalled edges.
REQ-038 Load ALU_VAL=0x13 -> STALL=0, ALIGN_ERR=1 for one cycle, REG_WRITE_OUT=0, array unchanged.
REQ-039 ALU op ALU_VAL=0x1234, REG_WRITE=1, BRANCH_CTRL=1, ZERO=1, BRANCH=0x40 -> no stall; PC_SRC=1, BRANCH_TARGET=0x40; next edge ALU_VAL_OUT=0x1234, READ_DATA_OUT=0.
REQ-040 DEPTH_LOG2=8, store 0x400 value 0x55 -> word 0 changes (wrap-around).
REQ-041 Store started, RESET pulsed in BUSY -> outputs 0, STALL=0, FSM IDLE, target word keeps its old value.
